cam_fb_writer: RTL and testbench
================================

CAM_FB_WRITER -- requirements
Module: cam_fb_writer

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 320, meaning the pixels per stored line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 240, meaning the lines per stored frame.
REQ-003 The block SHALL have parameter VS_ACTIVE_HIGH, default 1, meaning cam_vsync is asserted high when 1.
REQ-004 The block SHALL have port cam_clk, input, 1 bit: the camera pixel clock and the only clock, with all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port capture_en, input, 1 bit: arms capture of frames.
REQ-007 The block SHALL have port cam_vsync, input, 1 bit: the camera frame sync.
REQ-008 The block SHALL have port cam_href, input, 1 bit: high while line bytes are valid.
REQ-009 The block SHALL have port cam_data, input, 8 bits: the camera byte bus carrying RGB565, high byte first.
REQ-010 The block SHALL have port fb_wr_en, output, 1 bit: the framebuffer write strobe, one pixel per asserted cycle.
REQ-011 The block SHALL have port fb_wr_addr, output, 17 bits: the write address, row*H_ACTIVE+col.
REQ-012 The block SHALL have port fb_wr_data, output, 16 bits: the RGB565 pixel.
REQ-013 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse at the end of a captured frame.
REQ-014 The block SHALL have port frame_err, output, 1 bit: sticky, set when a captured frame's line count is not V_ACTIVE.
REQ-015 The block SHALL have port busy, output, 1 bit: high in state CAPTURE.

Function
REQ-016 The block SHALL register cam_vsync, cam_href and cam_data in one input stage; all decisions SHALL use the registered copies (vs_r, href_r, d_r).
REQ-017 The FSM SHALL have states IDLE, WAIT_FRAME and CAPTURE.
- IDLE -> WAIT_FRAME when capture_en=1.
- WAIT_FRAME -> CAPTURE on the vs_r deassert edge (active-to-inactive).
- CAPTURE -> WAIT_FRAME on the vs_r assert edge, with frame_done pulsed.
REQ-018 Dropping capture_en SHALL be honoured only at a frame boundary: at the vs_r assert edge the FSM goes to IDLE instead of WAIT_FRAME, and frame_done is still pulsed.
REQ-019 In WAIT_FRAME, byte phase, col and row SHALL be held at 0.
REQ-020 In CAPTURE, each cycle with href_r=1 SHALL toggle the byte phase: phase 0 latches the high byte; phase 1 forms {high, d_r}.
REQ-021 The block SHALL assert fb_wr_en for exactly one cycle, one cycle after the phase-1 sample, with fb_wr_addr=row*H_ACTIVE+col and fb_wr_data={high, low}.
REQ-022 Write latency SHALL be 2 cam_clk cycles from the edge that samples the low byte on cam_data to fb_wr_en=1.
REQ-023 col SHALL increment after each pixel and saturate at H_ACTIVE; pixels with col>=H_ACTIVE SHALL be dropped (no write).
REQ-024 On an href_r falling edge in CAPTURE, the block SHALL reset col and byte phase to 0 and increment row, saturating at V_ACTIVE.
REQ-025 Lines with row>=V_ACTIVE SHALL produce no writes.
REQ-026 An odd byte count at line end SHALL discard the dangling high byte without writing.
REQ-027 The fb_wr_addr computation SHALL use only shifts/adds or a running counter and SHALL NOT exceed H_ACTIVE*V_ACTIVE-1 (76799).
REQ-028 At frame end, frame_err SHALL be set if row≠V_ACTIVE; frame_err SHALL be cleared only on the IDLE->WAIT_FRAME transition.
REQ-029 If an href_r falling edge and the vs_r assert edge occur in the same cycle, the row increment SHALL be applied before the frame-length check.
REQ-030 href_r edges in IDLE or WAIT_FRAME SHALL be ignored.

Reset
REQ-031 While rst_n=0, the block SHALL be in state IDLE with fb_wr_en=0, fb_wr_addr=0, fb_wr_data=0, frame_done=0, frame_err=0 and busy=0, and the input registers, row, col and phase SHALL all be 0.
REQ-032 Reset asserted mid-line SHALL abort any pending write; no fb_wr_en SHALL be asserted after reset is released until a new WAIT_FRAME->CAPTURE transition.

Structure
REQ-033 A shared package SHALL hold H_ACTIVE and V_ACTIVE defaults, FB_ADDR_W=17, FB_DATA_W=16 and the FSM state encoding; the same H_ACTIVE SHALL be used by the framebuffer reader.
REQ-034 The block SHALL contain one natural sub-module, cam_byte_packer (byte phase plus 16-bit assembly, with an odd-byte discard output).

Verification
REQ-035 Full frame: capture_en=1, vsync pulse, then 240 lines of 640 bytes (pixel value = address[15:0]), then vsync -> 76800 writes, last write addr 76799, frame_done pulsed once, frame_err=0.
REQ-036 Latency: high byte 0xF8 then low byte 0x1F -> fb_wr_en asserted exactly 2 cycles after the 0x1F sample edge with data 0xF81F at addr 0.
REQ-037 Overlong line and short frame: lines of 700 bytes, 100 lines -> only cols 0..319 written, 32000 writes, frame_err=1 after vsync.
REQ-038 Odd bytes: line of 641 bytes -> 320 writes, no write for byte 641, next line starts at addr 320 with correct byte pairing.
REQ-039 Disarm: capture_en dropped mid-frame -> frame completes fully, frame_done pulsed, FSM in IDLE, no writes on the next frame.
REQ-040 Reset mid-line: rst_n pulsed low after byte 101 -> outputs 0 immediately (asynchronous), no writes until after the next vsync deassert edge.

Source files
------------

// File: rtl/cam_fb_writer_pkg.sv
// Shared definitions for the camera-to-framebuffer writer and the framebuffer reader.
package cam_fb_writer_pkg;

  localparam int unsigned H_ACTIVE_DEF = 320;
  localparam int unsigned V_ACTIVE_DEF = 240;
  localparam int unsigned FB_ADDR_W    = 17;
  localparam int unsigned FB_DATA_W    = 16;
  localparam int unsigned CAM_DATA_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_CAPTURE    = 2'd2
  } state_e;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_wr_t;

endpackage

// File: rtl/cam_fb_writer_if.sv
// Camera byte bus in, framebuffer write port out; master drives the camera side.
interface cam_fb_writer_if;
  import cam_fb_writer_pkg::*;

  logic                  cam_vsync;
  logic                  cam_href;
  logic [CAM_DATA_W-1:0] cam_data;
  logic                  fb_wr_en;
  logic [FB_ADDR_W-1:0]  fb_wr_addr;
  logic [FB_DATA_W-1:0]  fb_wr_data;

  modport master (
    output cam_vsync, cam_href, cam_data,
    input  fb_wr_en, fb_wr_addr, fb_wr_data
  );

  modport slave (
    input  cam_vsync, cam_href, cam_data,
    output fb_wr_en, fb_wr_addr, fb_wr_data
  );

endinterface

// File: rtl/cam_byte_packer.sv
// Pairs camera bytes (high first) into RGB565 pixels; clear drops a dangling high byte.
module cam_byte_packer
  import cam_fb_writer_pkg::*;
(
  input  logic                  cam_clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  sample_i,
  input  logic [CAM_DATA_W-1:0] byte_i,
  output logic                  pix_vld_o,
  output logic [FB_DATA_W-1:0]  pix_o,
  output logic                  odd_drop_o
);

  logic                  phase_q;
  logic [CAM_DATA_W-1:0] high_q;
  logic                  pix_vld_q;
  logic [FB_DATA_W-1:0]  pix_q;
  logic                  odd_drop_q;

  always_ff @(posedge cam_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= 1'b0;
      high_q     <= '0;
      pix_vld_q  <= 1'b0;
      pix_q      <= '0;
      odd_drop_q <= 1'b0;
    end else begin
      pix_vld_q  <= 1'b0;
      odd_drop_q <= 1'b0;
      if (clear_i) begin
        odd_drop_q <= phase_q;
        phase_q    <= 1'b0;
      end else if (sample_i) begin
        if (!phase_q) begin
          high_q <= byte_i;
        end else begin
          pix_q     <= {high_q, byte_i};
          pix_vld_q <= 1'b1;
        end
        phase_q <= ~phase_q;
      end
    end
  end

  assign pix_vld_o  = pix_vld_q;
  assign pix_o      = pix_q;
  assign odd_drop_o = odd_drop_q;

endmodule

// File: rtl/cam_fb_writer.sv
// Captures RGB565 camera frames into a framebuffer, one write per assembled pixel.
module cam_fb_writer
  import cam_fb_writer_pkg::*;
#(
  parameter int unsigned H_ACTIVE       = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE       = V_ACTIVE_DEF,
  parameter bit          VS_ACTIVE_HIGH = 1'b1
) (
  input  logic           cam_clk,
  input  logic           rst_n,
  input  logic           capture_en,
  cam_fb_writer_if.slave bus,
  output logic           frame_done,
  output logic           frame_err,
  output logic           busy
);

  localparam int unsigned COL_W = $clog2(H_ACTIVE + 1);
  localparam int unsigned ROW_W = $clog2(V_ACTIVE + 1);

  logic                  vs_r, href_r, vs_prev_q, href_prev_q;
  logic [CAM_DATA_W-1:0] d_r;
  state_e                state_q;
  logic                  busy_q, done_q, err_q, wr_en_q;
  fb_wr_t                wr_q;
  logic [COL_W-1:0]      col_q;
  logic [ROW_W-1:0]      row_q, row_inc, row_final;
  logic [FB_ADDR_W-1:0]  base_q;
  logic                  vs_act, vs_rise, vs_fall, href_fall, in_cap;
  logic                  col_ok, row_ok, pix_vld, odd_drop;
  logic [FB_DATA_W-1:0]  pix;

  // Single input stage; every decision below uses only these copies.
  always_ff @(posedge cam_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r        <= 1'b0;
      href_r      <= 1'b0;
      d_r         <= '0;
      vs_prev_q   <= 1'b0;
      href_prev_q <= 1'b0;
    end else begin
      vs_r        <= bus.cam_vsync;
      href_r      <= bus.cam_href;
      d_r         <= bus.cam_data;
      vs_prev_q   <= vs_act;
      href_prev_q <= href_r;
    end
  end

  assign vs_act    = (vs_r == VS_ACTIVE_HIGH);
  assign vs_rise   = vs_act & ~vs_prev_q;
  assign vs_fall   = ~vs_act & vs_prev_q;
  assign href_fall = href_prev_q & ~href_r;
  assign in_cap    = (state_q == ST_CAPTURE);
  assign col_ok    = (col_q < COL_W'(H_ACTIVE));
  assign row_ok    = (row_q < ROW_W'(V_ACTIVE));
  assign row_inc   = row_ok ? row_q + ROW_W'(1) : row_q;
  // A line ending on the same edge as vsync still counts toward the frame length.
  assign row_final = href_fall ? row_inc : row_q;

  cam_byte_packer u_packer (
    .cam_clk    (cam_clk),
    .rst_n      (rst_n),
    .clear_i    (~in_cap | href_fall),
    .sample_i   (in_cap & href_r),
    .byte_i     (d_r),
    .pix_vld_o  (pix_vld),
    .pix_o      (pix),
    .odd_drop_o (odd_drop)
  );

  always_ff @(posedge cam_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_en_q <= 1'b0;
      wr_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          col_q  <= '0;
          row_q  <= '0;
          base_q <= '0;
          if (capture_en) begin
            state_q <= ST_WAIT_FRAME;
            err_q   <= 1'b0;
          end
        end
        ST_WAIT_FRAME: begin
          col_q  <= '0;
          row_q  <= '0;
          base_q <= '0;
          if (vs_fall) begin
            state_q <= ST_CAPTURE;
            busy_q  <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (pix_vld && !odd_drop && col_ok) begin
            col_q <= col_q + COL_W'(1);
            if (row_ok) begin
              wr_en_q   <= 1'b1;
              wr_q.addr <= base_q + FB_ADDR_W'(col_q);
              wr_q.data <= pix;
            end
          end
          // Running line base keeps the address free of a multiplier.
          if (href_fall) begin
            col_q <= '0;
            row_q <= row_inc;
            if (row_ok) base_q <= base_q + FB_ADDR_W'(H_ACTIVE);
          end
          if (vs_rise) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= capture_en ? ST_WAIT_FRAME : ST_IDLE;
            if (row_final != ROW_W'(V_ACTIVE)) err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fb_wr_en   = wr_en_q;
  assign bus.fb_wr_addr = wr_q.addr;
  assign bus.fb_wr_data = wr_q.data;
  assign frame_done     = done_q;
  assign frame_err      = err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_cam_fb_writer.sv
// Scoreboard bench for cam_fb_writer on a reduced 8x4 frame.
module tb_cam_fb_writer;
  import cam_fb_writer_pkg::*;

  localparam int unsigned H_T = 8;
  localparam int unsigned V_T = 4;

  logic cam_clk = 1'b0;
  logic rst_n, capture_en;
  logic frame_done, frame_err, busy;

  cam_fb_writer_if bus ();

  cam_fb_writer #(.H_ACTIVE(H_T), .V_ACTIVE(V_T), .VS_ACTIVE_HIGH(1'b1)) dut (
    .cam_clk    (cam_clk),
    .rst_n      (rst_n),
    .capture_en (capture_en),
    .bus        (bus),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 cam_clk = ~cam_clk;

  int            n_checks = 0;
  int            n_pass   = 0;
  fb_wr_t        exp_q[$];
  fb_wr_t        mon_e;
  int            wr_cnt   = 0;
  int            done_cnt = 0;
  logic [16:0]   last_addr = '0;
  int unsigned   frame_row = 0;
  logic [15:0]   salt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every write must match the oldest queued expectation.
  always @(negedge cam_clk) begin
    if (rst_n === 1'b1) begin
      if (frame_done === 1'b1) done_cnt++;
      if (bus.fb_wr_en === 1'b1) begin
        wr_cnt++;
        last_addr = bus.fb_wr_addr;
        check("write_was_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(bus.fb_wr_addr), 32'(mon_e.addr));
          check("wr_data", 32'(bus.fb_wr_data), 32'(mon_e.data));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge cam_clk);
  endtask

  function automatic logic [15:0] pixval(input int unsigned row, input int unsigned col);
    return 16'(row * H_T + col) ^ salt;
  endfunction

  task automatic vsync_pulse();
    bus.cam_vsync = 1'b1;
    tick(4);
    bus.cam_vsync = 1'b0;
    tick(4);
    frame_row = 0;
  endtask

  task automatic send_line(input int unsigned nbytes, input bit expect_wr);
    for (int unsigned i = 0; i < nbytes; i++) begin
      int unsigned col = i / 2;
      logic [15:0] p = pixval(frame_row, col);
      bus.cam_href = 1'b1;
      bus.cam_data = (i % 2 == 0) ? p[15:8] : p[7:0];
      if ((i % 2 == 1) && expect_wr && frame_row < V_T && col < H_T)
        exp_q.push_back('{addr: 17'(frame_row * H_T + col), data: p});
      tick(1);
    end
    bus.cam_href = 1'b0;
    bus.cam_data = '0;
    tick(4);
    frame_row++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; capture_en = 1'b0;
    bus.cam_vsync = 1'b0; bus.cam_href = 1'b0; bus.cam_data = '0;
    tick(3);
    check("rst_wr_en", 32'(bus.fb_wr_en), 0);
    check("rst_wr_addr", 32'(bus.fb_wr_addr), 0);
    check("rst_wr_data", 32'(bus.fb_wr_data), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_err", 32'(frame_err), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick(2);

    // Frame 1: full frame, pixel value equals address.
    capture_en = 1'b1;
    tick(2);
    check("wait_not_busy", 32'(busy), 0);
    vsync_pulse();
    check("f1_busy", 32'(busy), 1);
    salt = 16'h0000;
    repeat (V_T) send_line(2 * H_T, 1'b1);
    vsync_pulse();
    check("f1_done_cnt", 32'(done_cnt), 1);
    check("f1_err", 32'(frame_err), 0);
    check("f1_wr_cnt", 32'(wr_cnt), 32);
    check("f1_last_addr", 32'(last_addr), 31);
    check("f1_rearmed_busy", 32'(busy), 1);

    // Frame 2: latency line, odd line, overlong line, short frame.
    bus.cam_href = 1'b1; bus.cam_data = 8'hF8;
    exp_q.push_back('{addr: 17'd0, data: 16'hF81F});
    tick(1);
    bus.cam_data = 8'h1F;
    tick(1);
    bus.cam_href = 1'b0; bus.cam_data = '0;
    tick(1);
    check("lat_early", 32'(bus.fb_wr_en), 0);
    tick(1);
    check("lat_en", 32'(bus.fb_wr_en), 1);
    check("lat_addr", 32'(bus.fb_wr_addr), 0);
    check("lat_data", 32'(bus.fb_wr_data), 32'h0000F81F);
    tick(1);
    check("lat_one_cycle", 32'(bus.fb_wr_en), 0);
    tick(2);
    frame_row = 1;
    salt = 16'h4400;
    send_line(7, 1'b1);
    send_line(20, 1'b1);
    vsync_pulse();
    check("f2_done_cnt", 32'(done_cnt), 2);
    check("f2_err", 32'(frame_err), 1);
    check("f2_wr_cnt", 32'(wr_cnt), 44);

    // Frame 3: five lines, disarm mid-frame; frame still completes.
    salt = 16'h7700;
    send_line(2 * H_T, 1'b1);
    send_line(2 * H_T, 1'b1);
    capture_en = 1'b0;
    repeat (3) send_line(2 * H_T, 1'b1);
    vsync_pulse();
    check("f3_done_cnt", 32'(done_cnt), 3);
    check("f3_err_sticky", 32'(frame_err), 1);
    check("f3_wr_cnt", 32'(wr_cnt), 76);
    check("f3_idle", 32'(busy), 0);

    // Frame 4: disarmed, nothing written.
    repeat (2) send_line(2 * H_T, 1'b0);
    vsync_pulse();
    check("f4_done_cnt", 32'(done_cnt), 3);
    check("f4_wr_cnt", 32'(wr_cnt), 76);
    check("f4_idle", 32'(busy), 0);

    // Re-arm clears the error; then reset in the middle of a line.
    capture_en = 1'b1;
    tick(2);
    check("rearm_err_clr", 32'(frame_err), 0);
    vsync_pulse();
    check("f5_busy", 32'(busy), 1);
    salt = 16'h0F0F;
    for (int unsigned i = 0; i < 5; i++) begin
      logic [15:0] p = pixval(0, i / 2);
      bus.cam_href = 1'b1;
      bus.cam_data = (i % 2 == 0) ? p[15:8] : p[7:0];
      if (i == 1) exp_q.push_back('{addr: 17'd0, data: p});
      tick(1);
    end
    check("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_wr_en", 32'(bus.fb_wr_en), 0);
    check("arst_wr_data", 32'(bus.fb_wr_data), 0);
    tick(2);
    rst_n = 1'b1;
    send_line(12, 1'b0);
    send_line(2 * H_T, 1'b0);
    check("post_rst_wr_cnt", 32'(wr_cnt), 77);
    check("post_rst_busy", 32'(busy), 0);

    // Frame 6: clean capture after reset.
    vsync_pulse();
    salt = 16'h3C3C;
    repeat (V_T) send_line(2 * H_T, 1'b1);
    vsync_pulse();
    check("f6_done_cnt", 32'(done_cnt), 4);
    check("f6_err", 32'(frame_err), 0);
    check("f6_wr_cnt", 32'(wr_cnt), 109);
    check("f6_last_addr", 32'(last_addr), 31);

    tick(10);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
